// File: rtl/pm_ctrl_pkg.sv
// Shared definitions for the program-memory fetch sequencer.
package pm_ctrl_pkg;

    localparam int unsigned     PM_ADDR_W     = 16;
    localparam logic [15:0]     PM_IRQ_VECTOR = 16'h0004;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } pm_state_e;

endpackage

// File: rtl/pm_fetch_ctrl.sv
// Fetch sequencer: drives program-memory select/hold controls from branch,
// interrupt, hazard and halt requests, and qualifies words arriving at decode.
module pm_fetch_ctrl
    import pm_ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W     = PM_ADDR_W,
    parameter logic [ADDR_W-1:0]  IRQ_VECTOR = ADDR_W'(PM_IRQ_VECTOR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cur_addr,
    input  logic              hazard_stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              irq_req,
    input  logic              irq_en,
    input  logic              halt_req,
    output logic              pm_rst_n,
    output logic              stall,
    output logic              stall_pm,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              fetch_valid,
    output logic              flush,
    output logic              irq_ack,
    output logic [ADDR_W-1:0] epc,
    output logic              halted
);

    pm_state_e state, state_nxt;
    logic      irq_take;
    logic      take_br;
    logic      take_irq;
    logic      first_run;

    assign irq_take = irq_req & irq_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        take_br   = 1'b0;
        take_irq  = 1'b0;
        case (state)
            ST_BOOT: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (br_taken) begin
                    take_br   = 1'b1;
                    state_nxt = ST_REDIRECT;
                end else if (irq_take) begin
                    take_irq  = 1'b1;
                    state_nxt = ST_REDIRECT;
                end else if (halt_req) begin
                    state_nxt = ST_HALT;
                end else if (hazard_stall) begin
                    stall = 1'b1;
                end
            end
            ST_REDIRECT: begin
                state_nxt = ST_RUN;
            end
            ST_HALT: begin
                stall = 1'b1;
                // Interrupt wakes the core; branches are ignored while parked.
                if (irq_take) begin
                    take_irq  = 1'b1;
                    state_nxt = ST_REDIRECT;
                end else if (!halt_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jmp_loc   <= '0;
            epc       <= '0;
            irq_ack   <= 1'b0;
            stall_pm  <= 1'b0;
            first_run <= 1'b0;
        end else begin
            stall_pm  <= stall;
            irq_ack   <= take_irq;
            first_run <= (state == ST_BOOT);
            if (take_br) begin
                jmp_loc <= br_target;
            end else if (take_irq) begin
                jmp_loc <= IRQ_VECTOR;
                epc     <= cur_addr;
            end
        end
    end

    assign pm_rst_n    = (state != ST_BOOT);
    assign pc_mux_sel  = (state == ST_REDIRECT);
    assign flush       = (state == ST_REDIRECT);
    assign halted      = (state == ST_HALT);
    // Memory output is not valid yet in the first RUN cycle after BOOT.
    assign fetch_valid = (state == ST_RUN) && !flush && !first_run;

endmodule

// File: tb/tb_pm_fetch_ctrl.sv
// Directed self-checking bench for pm_fetch_ctrl with a small program-counter model.
module tb_pm_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cur_addr;
    logic        hazard_stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic        irq_req;
    logic        irq_en;
    logic        halt_req;
    logic        pm_rst_n;
    logic        stall;
    logic        stall_pm;
    logic        pc_mux_sel;
    logic [15:0] jmp_loc;
    logic        fetch_valid;
    logic        flush;
    logic        irq_ack;
    logic [15:0] epc;
    logic        halted;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          cyc   = 0;
    logic [15:0] pc;

    pm_fetch_ctrl #(.ADDR_W(16), .IRQ_VECTOR(16'h0004)) dut (
        .clk          (clk),
        .reset        (reset),
        .cur_addr     (cur_addr),
        .hazard_stall (hazard_stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .irq_req      (irq_req),
        .irq_en       (irq_en),
        .halt_req     (halt_req),
        .pm_rst_n     (pm_rst_n),
        .stall        (stall),
        .stall_pm     (stall_pm),
        .pc_mux_sel   (pc_mux_sel),
        .jmp_loc      (jmp_loc),
        .fetch_valid  (fetch_valid),
        .flush        (flush),
        .irq_ack      (irq_ack),
        .epc          (epc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Program-memory address model: reset, redirect, hold, or increment.
    always @(posedge clk) begin
        if (!pm_rst_n)       pc <= 16'h0000;
        else if (pc_mux_sel) pc <= jmp_loc;
        else if (!stall)     pc <= pc + 16'h0001;
    end
    assign cur_addr = pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pm_rst_n"},    32'(pm_rst_n),    0);
        check({tag, ".stall"},       32'(stall),       0);
        check({tag, ".stall_pm"},    32'(stall_pm),    0);
        check({tag, ".pc_mux_sel"},  32'(pc_mux_sel),  0);
        check({tag, ".jmp_loc"},     32'(jmp_loc),     0);
        check({tag, ".fetch_valid"}, 32'(fetch_valid), 0);
        check({tag, ".flush"},       32'(flush),       0);
        check({tag, ".irq_ack"},     32'(irq_ack),     0);
        check({tag, ".epc"},         32'(epc),         0);
        check({tag, ".halted"},      32'(halted),      0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hazard_stall = 1'b0; br_taken = 1'b0; br_target = '0;
        irq_req = 1'b0; irq_en = 1'b0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("rst");

        // Boot sequence
        @(posedge clk); #1; reset = 1'b0; cyc = 0;
        #1;
        check("boot0.pm_rst_n", 32'(pm_rst_n), 0);
        check("boot0.fv", 32'(fetch_valid), 0);
        step(); #1;
        check("boot1.pm_rst_n", 32'(pm_rst_n), 1);
        check("boot1.fv", 32'(fetch_valid), 0);
        check("boot1.stall", 32'(stall), 0);
        check("boot1.pcsel", 32'(pc_mux_sel), 0);
        check("boot1.flush", 32'(flush), 0);
        check("boot1.halted", 32'(halted), 0);
        step(); #1;
        check("boot2.fv", 32'(fetch_valid), 1);

        // Branch together with hazard: branch wins, no stall
        goto(10);
        br_taken = 1'b1; br_target = 16'h0040; hazard_stall = 1'b1;
        #1;
        check("br10.stall", 32'(stall), 0);
        check("br10.pcsel", 32'(pc_mux_sel), 0);
        step(); br_taken = 1'b0; hazard_stall = 1'b0; #1;
        check("br11.pcsel", 32'(pc_mux_sel), 1);
        check("br11.jmp", 32'(jmp_loc), 32'h0040);
        check("br11.flush", 32'(flush), 1);
        check("br11.fv", 32'(fetch_valid), 0);
        check("br11.stall", 32'(stall), 0);
        step(); #1;
        check("br12.fv", 32'(fetch_valid), 1);
        check("br12.pcsel", 32'(pc_mux_sel), 0);
        check("br12.addr", 32'(cur_addr), 32'h0040);

        // Hazard over cycles 20..22
        goto(20);
        for (int i = 20; i <= 24; i++) begin
            if (i > 20) step();
            hazard_stall = (i <= 22);
            #1;
            check("haz.stall", 32'(stall), (i <= 22) ? 1 : 0);
            check("haz.stall_pm", 32'(stall_pm), (i >= 21 && i <= 23) ? 1 : 0);
            check("haz.addr", 32'(cur_addr), (i <= 23) ? 32'h0048 : 32'h0049);
        end

        // Interrupt and branch together: branch first, interrupt next RUN cycle
        goto(30);
        irq_en = 1'b1; irq_req = 1'b1; br_taken = 1'b1; br_target = 16'h0012;
        #1;
        check("irq30.ack", 32'(irq_ack), 0);
        step(); br_taken = 1'b0; #1;
        check("irq31.pcsel", 32'(pc_mux_sel), 1);
        check("irq31.jmp", 32'(jmp_loc), 32'h0012);
        check("irq31.ack", 32'(irq_ack), 0);
        step(); #1;
        check("irq32.ack", 32'(irq_ack), 0);
        check("irq32.fv", 32'(fetch_valid), 1);
        check("irq32.addr", 32'(cur_addr), 32'h0012);
        step(); irq_req = 1'b0; #1;
        check("irq33.ack", 32'(irq_ack), 1);
        check("irq33.jmp", 32'(jmp_loc), 32'h0004);
        check("irq33.epc", 32'(epc), 32'h0012);
        check("irq33.pcsel", 32'(pc_mux_sel), 1);
        check("irq33.flush", 32'(flush), 1);
        step(); #1;
        check("irq34.ack", 32'(irq_ack), 0);
        check("irq34.addr", 32'(cur_addr), 32'h0004);
        check("irq34.fv", 32'(fetch_valid), 1);

        // Halt held for cycles 40..44
        goto(40);
        halt_req = 1'b1; #1;
        check("halt40.halted", 32'(halted), 0);
        for (int i = 41; i <= 44; i++) begin
            step(); #1;
            check("halt.halted", 32'(halted), 1);
            check("halt.stall", 32'(stall), 1);
            check("halt.fv", 32'(fetch_valid), 0);
        end
        step(); halt_req = 1'b0; #1;
        check("halt45.halted", 32'(halted), 1);
        step(); #1;
        check("halt46.halted", 32'(halted), 0);
        check("halt46.stall", 32'(stall), 0);
        check("halt46.fv", 32'(fetch_valid), 1);

        // Halt, ignored branch, then interrupt wake-up
        goto(50);
        halt_req = 1'b1;
        step(); #1;
        check("wake51.halted", 32'(halted), 1);
        step(); br_taken = 1'b1; br_target = 16'h0080; #1;
        check("wake52.halted", 32'(halted), 1);
        check("wake52.stall", 32'(stall), 1);
        step(); br_taken = 1'b0; irq_req = 1'b1; #1;
        check("wake53.jmp", 32'(jmp_loc), 32'h0004);
        check("wake53.halted", 32'(halted), 1);
        check("wake53.addr", 32'(cur_addr), 32'h0010);
        step(); irq_req = 1'b0; halt_req = 1'b0; #1;
        check("wake54.halted", 32'(halted), 0);
        check("wake54.ack", 32'(irq_ack), 1);
        check("wake54.pcsel", 32'(pc_mux_sel), 1);
        check("wake54.jmp", 32'(jmp_loc), 32'h0004);
        check("wake54.epc", 32'(epc), 32'h0010);
        step(); #1;
        check("wake55.fv", 32'(fetch_valid), 1);
        check("wake55.addr", 32'(cur_addr), 32'h0004);

        // Reset pulsed mid-REDIRECT
        goto(60);
        br_taken = 1'b1; br_target = 16'h0077;
        step(); br_taken = 1'b0; #1;
        check("rr61.pcsel", 32'(pc_mux_sel), 1);
        check("rr61.jmp", 32'(jmp_loc), 32'h0077);
        #1; reset = 1'b1; #1;
        check_all_zero("rr_async");
        @(posedge clk);
        @(posedge clk); #1; reset = 1'b0; cyc = 0;
        #1;
        check("reboot0.pm_rst_n", 32'(pm_rst_n), 0);
        step(); #1;
        check("reboot1.pm_rst_n", 32'(pm_rst_n), 1);
        check("reboot1.fv", 32'(fetch_valid), 0);
        step(); #1;
        check("reboot2.fv", 32'(fetch_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pm_fetch_ctrl.md
# pm_fetch_ctrl

Fetch sequencer for the program-memory stage. It drives the address-select and hold controls of the program-memory block (`pc_mux_sel`, `stall`, `stall_pm`, `jmp_loc`, active-low memory reset), using branch, interrupt, hazard and halt requests from the decode/execute stages. It also tells decode which fetched words are valid and which must be flushed. It sits between the program-memory block and the decode stage, one instance per core.

## Interface
- `IRQ_VECTOR`, default 16'h0004: fetch address taken on interrupt entry.
- `ADDR_W`, default 16: program-address width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cur_addr` in ADDR_W: current fetch address returned by program memory.
- `hazard_stall` in 1: decode requests a freeze this cycle.
- `br_taken` in 1: branch/jump resolved taken (one-cycle pulse).
- `br_target` in ADDR_W: branch target, valid with `br_taken`.
- `irq_req` in 1: level interrupt request.
- `irq_en` in 1: interrupts enabled.
- `halt_req` in 1: level request to park fetch.
- `pm_rst_n` out 1: active-low reset to program memory.
- `stall` out 1: hold fetch address.
- `stall_pm` out 1: select the held instruction.
- `pc_mux_sel` out 1: select `jmp_loc`.
- `jmp_loc` out ADDR_W: redirect address.
- `fetch_valid` out 1: instruction word at decode this cycle is valid.
- `flush` out 1: kill instruction word at decode this cycle.
- `irq_ack` out 1: one-cycle interrupt-entry pulse.
- `epc` out ADDR_W: return address latched on interrupt entry.
- `halted` out 1: fetch parked.

## Operation
- States: BOOT, RUN, REDIRECT, HALT. Encoding is held in a shared package.
- Reset (async) forces the state to BOOT and sets the reset values below.
- Reset values of outputs: `pm_rst_n`=0, `stall`=0, `stall_pm`=0, `pc_mux_sel`=0, `jmp_loc`=0, `fetch_valid`=0, `flush`=0, `irq_ack`=0, `epc`=0, `halted`=0.
- BOOT:
  - Lasts exactly one cycle after reset deassertion, with `pm_rst_n`=0.
  - Then goes to RUN with `pm_rst_n`=1 for as long as `reset` is low.
- RUN, evaluated each cycle with priority `br_taken` > (`irq_req`&`irq_en`) > `halt_req` > `hazard_stall`:
  - `br_taken`: register `br_target` into `jmp_loc`, go to REDIRECT.
  - Interrupt: register `IRQ_VECTOR` into `jmp_loc`, register `cur_addr` into `epc`, pulse `irq_ack` in the next cycle, go to REDIRECT.
  - `halt_req`: go to HALT.
  - `hazard_stall`: `stall`=1 combinationally in the same cycle; stay in RUN.
- REDIRECT:
  - Lasts one cycle: `pc_mux_sel`=1, `flush`=1, `fetch_valid`=0, `stall`=0.
  - Then returns to RUN.
  - All requests arriving in REDIRECT are ignored except `reset`. Branch sources must not re-issue `br_taken` for the flushed word.
- HALT:
  - `stall`=1, `halted`=1, `fetch_valid`=0.
  - Leaves to RUN the cycle after `halt_req` falls.
  - `br_taken` in HALT is ignored.
  - An enabled interrupt in HALT goes to REDIRECT exactly as from RUN (wake-up).
- `stall_pm` is `stall` registered by one cycle, cleared by reset.
- `fetch_valid` = state==RUN and not `flush`, gated off in the first RUN cycle after BOOT (memory output not yet valid).
- Address arithmetic is not performed here; the sequential increment stays in program memory.

## Timing
- Cycle 0 is reset deassertion. Cycle 1 is the first RUN cycle; `pm_rst_n` rises at the start of cycle 1. `fetch_valid` first goes high in cycle 2.
- Branch latency:
  - `br_taken` at cycle n gives `pc_mux_sel`=1 and `jmp_loc`=target in n+1.
  - The word at decode in n+1 is flushed.
  - M[target] is at decode in n+2 with `fetch_valid`=1.
  - Exactly one bubble.
- Interrupt:
  - Entry at n gives `irq_ack`, `epc`=`cur_addr`(n), and redirect in n+1.
  - The handler's first word is at decode in n+2.
- Hazard: `stall` is asserted in the same cycle as `hazard_stall`; `stall_pm` in the following cycle.
- `br_taken` and `hazard_stall` together: the branch wins and `stall`=0.
- `reset` asserted mid-REDIRECT or mid-HALT returns to BOOT immediately and clears all outputs, including `epc`.

## Structure
- Shared package `pm_ctrl_pkg`: state enum, `ADDR_W` default, `IRQ_VECTOR` default.
- Single module, no sub-modules. The registered redirect/latch logic is small enough to stay inline.

## Test plan
- Reset then release at cycle 0: `pm_rst_n` is 0 in cycle 0 and 1 from cycle 1; `fetch_valid` is 0 in cycle 1 and 1 in cycle 2; all other outputs are 0.
- `br_taken`=1 with `br_target`=16'h0040 at cycle 10: cycle 11 has `pc_mux_sel`=1, `jmp_loc`=16'h0040, `flush`=1; cycle 12 has `fetch_valid`=1 and `pc_mux_sel`=0.
- `hazard_stall` high for cycles 20–22: `stall`=1 in cycles 20–22, `stall_pm`=1 in cycles 21–23, `cur_addr` constant over cycles 20–22.
- `irq_req`=1 with `irq_en`=1 and `cur_addr`=16'h0012, together with `br_taken` in the same cycle: the branch is taken first. On the next RUN cycle the interrupt is entered: `irq_ack`=1, `jmp_loc`=16'h0004, `epc` equal to `cur_addr` of the entry cycle.
- `halt_req` held for 5 cycles: `halted`=1 and `stall`=1 throughout. `irq_req` during the halt causes wake-up via REDIRECT; `halted`=0 in the cycle after entry.
- `reset` pulsed during REDIRECT: all outputs are 0 asynchronously and the BOOT sequence repeats.
